// File: rtl/read_inc_sync_if.sv
// Read-side bus of the async FIFO pointer logic: the read request, the
// synchronised write pointer, and the status and address outputs of
// read_inc_sync.
// Optional macro READ_UNDERFLOW_FLAG_EN adds the sticky underflow flag.
interface read_inc_sync_if #(
    parameter int ADDRSIZE = 4
);
    logic                signal_read;
    logic [ADDRSIZE:0]   graycode_wptr;
    logic                empty;
    logic [ADDRSIZE-1:0] read_address;
    logic [ADDRSIZE:0]   graycode_rptr;
    logic [ADDRSIZE:0]   rd_level;
    logic                almost_empty;
`ifdef READ_UNDERFLOW_FLAG_EN
    logic                underflow;
`endif

    // Consumer side: issues reads, sees status.
    modport master (
        output signal_read,
        output graycode_wptr,
        input  empty,
        input  read_address,
        input  graycode_rptr,
        input  rd_level,
`ifdef READ_UNDERFLOW_FLAG_EN
        input  underflow,
`endif
        input  almost_empty
    );

    // Pointer block side.
    modport slave (
        input  signal_read,
        input  graycode_wptr,
        output empty,
        output read_address,
        output graycode_rptr,
        output rd_level,
`ifdef READ_UNDERFLOW_FLAG_EN
        output underflow,
`endif
        output almost_empty
    );
endinterface

// File: rtl/read_inc_sync.sv
// read_inc_sync: read-domain pointer, empty flag, fill level and
// almost-empty generator for an async FIFO. The write side's Gray pointer
// is brought in through a two-flop synchroniser; the read pointer is
// returned in Gray code for the write side's full detection.
// Optional macro READ_UNDERFLOW_FLAG_EN adds a sticky underflow output.
module read_inc_sync #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input  logic           rclk,
    input  logic           rst_n,
    read_inc_sync_if.slave bus
);
    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    // Binary to Gray conversion.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary as a prefix-XOR running from the MSB down.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_wq1;
    logic [PW-1:0] r_wq2;
    logic [PW-1:0] r_read_counter;
    logic [PW-1:0] r_graycode_rptr;
    logic [PW-1:0] r_rd_level;
    logic          r_empty;
    logic          r_almost_empty;

    logic          w_read_ok;
    logic [PW-1:0] w_next_read;
    logic [PW-1:0] w_next_gray;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_next_level;
    logic          w_next_empty;
    logic          w_next_ae;

    // Next-state computation: counter advance, Gray pointer, empty and level.
    always_comb begin
        w_read_ok    = bus.signal_read & ~r_empty;
        w_next_read  = r_read_counter + {{ADDRSIZE{1'b0}}, w_read_ok};
        w_next_gray  = bin2gray(w_next_read);
        w_next_empty = (w_next_gray == r_wq2);
        w_wbin       = gray2bin(r_wq2);
        w_next_level = w_wbin - w_next_read;
        w_next_ae    = (w_next_level <= AE_LIM);
    end

    // Two-flop synchroniser for the write-domain Gray pointer.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wq1 <= {PW{1'b0}};
            r_wq2 <= {PW{1'b0}};
        end else begin
            r_wq1 <= bus.graycode_wptr;
            r_wq2 <= r_wq1;
        end
    end

    // Read pointer and registered status flags; empty and almost_empty come out of reset set.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_counter  <= {PW{1'b0}};
            r_graycode_rptr <= {PW{1'b0}};
            r_rd_level      <= {PW{1'b0}};
            r_empty         <= 1'b1;
            r_almost_empty  <= 1'b1;
        end else begin
            r_read_counter  <= w_next_read;
            r_graycode_rptr <= w_next_gray;
            r_rd_level      <= w_next_level;
            r_empty         <= w_next_empty;
            r_almost_empty  <= w_next_ae;
        end
    end

`ifdef READ_UNDERFLOW_FLAG_EN
    logic r_underflow;

    // Sticky flag recording any read attempted while the FIFO looked empty.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= r_underflow | (bus.signal_read & r_empty);
        end
    end

    assign bus.underflow = r_underflow;
`endif

    assign bus.empty         = r_empty;
    assign bus.read_address  = r_read_counter[ADDRSIZE-1:0];
    assign bus.graycode_rptr = r_graycode_rptr;
    assign bus.rd_level      = r_rd_level;
    assign bus.almost_empty  = r_almost_empty;

endmodule

// File: tb/tb_read_inc_sync.sv
// Directed self-checking bench for read_inc_sync (ADDRSIZE=4, AE_THRESH=2).
module tb_read_inc_sync;
    logic rclk;
    logic rst_n;
    int   checks;
    int   errors;

    read_inc_sync_if #(.ADDRSIZE(4)) bus ();

    read_inc_sync #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
        .rclk  (rclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.signal_read = 1'b0;
        bus.graycode_wptr = 5'd0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.signal_read = 1'b0;
        bus.graycode_wptr = 5'b00011;
        tick();
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", bus.empty); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae got %b want 1", bus.almost_empty); end
        checks++; if (bus.rd_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", bus.rd_level); end
        checks++; if (bus.graycode_rptr !== 5'd0) begin errors++; $display("FAIL rst_rptr got %b want 00000", bus.graycode_rptr); end
        checks++; if (bus.read_address !== 4'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", bus.read_address); end
`ifdef READ_UNDERFLOW_FLAG_EN
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow got %b want 0", bus.underflow); end
`endif
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rel_empty_e2 got %b want 1", bus.empty); end
        tick();
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL rel_empty_e3 got %b want 0", bus.empty); end
        checks++; if (bus.rd_level !== 5'd2) begin errors++; $display("FAIL rel_level got %0d want 2", bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL rel_ae got %b want 1", bus.almost_empty); end
    endtask

    task automatic test_sync_latency();
        do_reset();
        bus.graycode_wptr = 5'b00001;
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL lat_empty_n got %b want 1", bus.empty); end
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL lat_empty_n1 got %b want 1", bus.empty); end
        tick();
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL lat_empty_n2 got %b want 0", bus.empty); end
        checks++; if (bus.rd_level !== 5'd1) begin errors++; $display("FAIL lat_level got %0d want 1", bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL lat_ae got %b want 1", bus.almost_empty); end
    endtask

    task automatic test_drain();
        logic [4:0] exp_level;
        do_reset();
        bus.graycode_wptr = 5'b00010;
        repeat (3) tick();
        checks++; if (bus.rd_level !== 5'd3) begin errors++; $display("FAIL drain_level0 got %0d want 3", bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL drain_ae0 got %b want 0", bus.almost_empty); end
        bus.signal_read = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_level = 5'(3 - i);
            checks++; if (bus.read_address !== 4'(i)) begin errors++; $display("FAIL drain_addr%0d got %0d want %0d", i, bus.read_address, i); end
            checks++; if (bus.rd_level !== exp_level) begin errors++; $display("FAIL drain_level%0d got %0d want %0d", i, bus.rd_level, exp_level); end
            checks++; if (bus.empty !== (i == 3)) begin errors++; $display("FAIL drain_empty%0d got %b want %b", i, bus.empty, (i == 3)); end
        end
        tick();
        bus.signal_read = 1'b0;
        checks++; if (bus.read_address !== 4'd3) begin errors++; $display("FAIL drain_addr4 got %0d want 3", bus.read_address); end
        checks++; if (bus.graycode_rptr !== 5'b00010) begin errors++; $display("FAIL drain_rptr4 got %b want 00010", bus.graycode_rptr); end
        checks++; if (bus.rd_level !== 5'd0) begin errors++; $display("FAIL drain_level4 got %0d want 0", bus.rd_level); end
`ifdef READ_UNDERFLOW_FLAG_EN
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow got %b want 1", bus.underflow); end
`endif
    endtask

    task automatic test_full_depth();
        do_reset();
        bus.graycode_wptr = 5'b11000;
        repeat (3) tick();
        checks++; if (bus.rd_level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL full_ae got %b want 0", bus.almost_empty); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", bus.empty); end
        bus.signal_read = 1'b1;
        repeat (13) tick();
        checks++; if (bus.rd_level !== 5'd3) begin errors++; $display("FAIL full_level13 got %0d want 3", bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL full_ae13 got %b want 0", bus.almost_empty); end
        checks++; if (bus.read_address !== 4'd13) begin errors++; $display("FAIL full_addr13 got %0d want 13", bus.read_address); end
        tick();
        bus.signal_read = 1'b0;
        checks++; if (bus.rd_level !== 5'd2) begin errors++; $display("FAIL full_level14 got %0d want 2", bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL full_ae14 got %b want 1", bus.almost_empty); end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        do_reset();
        prev = 5'd0;
        for (int k = 1; k <= 34; k++) begin
            bus.graycode_wptr = gray5(k % 32);
            repeat (3) tick();
            checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL wrap_pre_empty k=%0d got %b want 0", k, bus.empty); end
            checks++; if (bus.rd_level !== 5'd1) begin errors++; $display("FAIL wrap_pre_level k=%0d got %0d want 1", k, bus.rd_level); end
            bus.signal_read = 1'b1;
            tick();
            bus.signal_read = 1'b0;
            checks++; if (bus.graycode_rptr !== gray5(k % 32)) begin errors++; $display("FAIL wrap_rptr k=%0d got %b want %b", k, bus.graycode_rptr, gray5(k % 32)); end
            checks++; if ($countones(prev ^ bus.graycode_rptr) != 1) begin errors++; $display("FAIL wrap_onebit k=%0d prev %b got %b want 1-bit change", k, prev, bus.graycode_rptr); end
            checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_post_empty k=%0d got %b want 1", k, bus.empty); end
            checks++; if (bus.read_address !== 4'(k % 16)) begin errors++; $display("FAIL wrap_addr k=%0d got %0d want %0d", k, bus.read_address, k % 16); end
            prev = bus.graycode_rptr;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.graycode_wptr = 5'b01111;
        repeat (3) tick();
        bus.signal_read = 1'b1;
        repeat (7) tick();
        bus.signal_read = 1'b0;
        checks++; if (bus.read_address !== 4'd7) begin errors++; $display("FAIL ar_pre_addr got %0d want 7", bus.read_address); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL ar_pre_empty got %b want 0", bus.empty); end
        checks++; if (bus.rd_level !== 5'd3) begin errors++; $display("FAIL ar_pre_level got %0d want 3", bus.rd_level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ar_empty got %b want 1", bus.empty); end
        checks++; if (bus.read_address !== 4'd0) begin errors++; $display("FAIL ar_addr got %0d want 0", bus.read_address); end
        checks++; if (bus.graycode_rptr !== 5'd0) begin errors++; $display("FAIL ar_rptr got %b want 00000", bus.graycode_rptr); end
        checks++; if (bus.rd_level !== 5'd0) begin errors++; $display("FAIL ar_level got %0d want 0", bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL ar_ae got %b want 1", bus.almost_empty); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.signal_read = 1'b0;
        bus.graycode_wptr = 5'd0;
        test_reset();
        test_sync_latency();
        test_drain();
        test_full_depth();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/read_inc_sync.md
Name: read_inc_sync

Overview:
- Read-side pointer and empty-flag generator for the async FIFO; sits directly downstream of the write-pointer block, in the read clock domain.
- Synchronises the write side's Gray-coded write pointer with two flip-flops.
- Advances the read pointer on accepted reads and drives the RAM read address.
- Produces a registered empty flag, fill level and almost-empty flag. It also returns its own Gray read pointer, which the write side synchronises for its full detection.

Parameters:
- ADDRSIZE, 4, RAM address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AE_THRESH, 2, almost_empty asserts when fill level <= AE_THRESH; legal range 0..2^ADDRSIZE.

Ports:
- rclk, input, 1, read clock; all state updates on its rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- signal_read, input, 1, read request; accepted only when empty=0.
- graycode_wptr, input, ADDRSIZE+1, Gray write pointer from the write clock domain (asynchronous to rclk).
- empty, output, 1, registered FIFO-empty flag.
- read_address, output, ADDRSIZE, RAM read address = read_counter[ADDRSIZE-1:0].
- graycode_rptr, output, ADDRSIZE+1, registered Gray read pointer for the write side.
- rd_level, output, ADDRSIZE+1, registered fill level as seen from the read domain, 0..2^ADDRSIZE.
- almost_empty, output, 1, registered: rd_level <= AE_THRESH.

Behaviour:
- Synchroniser: wq1 <= graycode_wptr; wq2 <= wq1. Only wq2 is used downstream; no logic between the stages.
- Binary counter: next_read = read_counter + (signal_read & ~empty), modulo 2^(ADDRSIZE+1).
- Gray conversion: next_gray = next_read ^ (next_read >> 1).
- Empty detection: next_empty = (next_gray == wq2), full ADDRSIZE+1 bits compared, no MSB inversion.
- Level calculation:
  - wbin = Gray-to-binary(wq2), computed as a prefix-XOR from the MSB down.
  - next_level = wbin - next_read, modulo 2^(ADDRSIZE+1).
- Registered updates each rclk edge: read_counter, graycode_rptr <= next_gray, empty <= next_empty, rd_level <= next_level, almost_empty <= (next_level <= AE_THRESH).
- Reset (rst_n low, asynchronous): wq1, wq2, read_counter, graycode_rptr and rd_level = 0; empty = 1; almost_empty = 1. On release, the first update happens at the next rclk edge.
- Latency:
  - A write-pointer change that is stable before rclk edge N is captured in wq1 at edge N and wq2 at N+1. empty, rd_level and almost_empty reflect it after edge N+2.
  - A read accepted at edge N moves read_address and graycode_rptr after edge N; empty can assert at that same edge.
- Read while empty: ignored. Counter, graycode_rptr and rd_level stay unchanged.
- Simultaneous accepted read and wq2 change in the same cycle: both are folded into next_empty and next_level in one update.
- Wrap-around: the counter rolls from 2^(ADDRSIZE+1)-1 to 0, and its Gray code differs by 1 bit. The level stays correct across the wrap because of the modulo subtraction.
- Pessimism: empty and rd_level may lag by up to 2 rclk + write-side latency. empty never deasserts early.
- Reset mid-operation: all state clears immediately regardless of signal_read. The write side must be reset in the same event.

Optional Feature:
- Macro: READ_UNDERFLOW_FLAG_EN.
- When defined, adds output port underflow (1 bit).
  - Sets on any rclk edge where signal_read=1 and empty=1.
  - Sticky until rst_n is low; reset value 0.
  - Does not alter pointer behaviour.
- When undefined, the port and its logic are absent. Reads while empty are silently dropped.

Test Plan (ADDRSIZE=4, AE_THRESH=2):
- Reset: hold rst_n=0 with graycode_wptr=5'b00011 -> empty=1, almost_empty=1, rd_level=0, graycode_rptr=0, read_address=0. Release -> after 3 rclk edges, empty=0 and rd_level=2 (Gray 00011 = binary 2).
- Sync latency: with the FIFO empty, change graycode_wptr 0 -> 5'b00001 just before edge N -> empty stays 1 through edge N+1 and reads 0 after edge N+2; rd_level=1, almost_empty=1.
- Drain: wptr = Gray(3) = 5'b00010, then 3 consecutive reads -> read_address 1,2,3; rd_level 2,1,0; empty=1 after the 3rd read. A 4th read leaves read_address=3 (underflow=1 if the macro is enabled).
- Full depth and almost_empty: wptr = Gray(16) = 5'b11000, rptr=0 -> rd_level=16, almost_empty=0. Read 13 times -> rd_level=3, almost_empty=0; 14th read -> rd_level=2, almost_empty=1.
- Wrap: advance through 34 writes and reads in steps -> read_counter goes 31 -> 0, graycode_rptr goes 10000 -> 00000. Each step changes exactly 1 bit, and empty is correct on both sides of the wrap.
- Async reset mid-stream: assert rst_n low between rclk edges with empty=0 and read_counter=7 -> outputs return to reset values immediately, without waiting for an rclk edge.
